// File: rtl/tile_obi_addr_demux_pkg.sv
// tile_obi_addr_demux_pkg: shared tile types and constants for the OBI address demux.
// Contents: address rule record {idx, start_addr, end_addr}, in-flight target
// kind, error-response data word and the default tile address map (L1, L2).
package tile_obi_addr_demux_pkg;

    localparam int unsigned RULE_ADDR_W = 32;

    typedef struct packed {
        logic [31:0]            idx;
        logic [RULE_ADDR_W-1:0] start_addr;
        logic [RULE_ADDR_W-1:0] end_addr;
    } rule_t;

    typedef enum logic {
        TGT_SBR = 1'b0,
        TGT_ERR = 1'b1
    } tgt_kind_e;

    localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;

    localparam rule_t L1_RULE = '{idx: 32'd0, start_addr: 32'h1000_0000, end_addr: 32'h2000_0000};
    localparam rule_t L2_RULE = '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000};

    // Element [0] is the lowest-numbered (highest priority) rule.
    localparam rule_t [1:0] DEFAULT_MAP = {L2_RULE, L1_RULE};

endpackage

// File: rtl/tile_obi_addr_demux_if.sv
// tile_obi_addr_demux_if: one OBI channel (address phase + response phase).
// master modport drives req/addr/we/be/wdata/aid and receives gnt/rvalid/rdata/err/rid;
// slave modport is the mirror image.
interface tile_obi_addr_demux_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1
);
    logic                req;
    logic                gnt;
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
    logic [ID_W-1:0]     aid;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic [ID_W-1:0]     rid;

    modport master (output req, addr, we, be, wdata, aid, input gnt, rvalid, rdata, err, rid);
    modport slave  (input req, addr, we, be, wdata, aid, output gnt, rvalid, rdata, err, rid);
endinterface

// File: rtl/tile_obi_err_sbr.sv
// tile_obi_err_sbr: internal subordinate that answers every decode-error access.
// Ports: clk_i, rst_ni (async active-low), bus (OBI slave). Grants in the request
// cycle and responds one cycle later with err=1, rdata=ERR_DATA and the captured aid.
module tile_obi_err_sbr
    import tile_obi_addr_demux_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1
) (
    input logic clk_i,
    input logic rst_ni,
    tile_obi_addr_demux_if.slave bus
);
    localparam int unsigned PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  fifo [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push, pop;

    // A queued entry is always answered in the very next cycle, so the FIFO
    // drains as fast as it can fill and the one-cycle latency is preserved.
    assign pop        = cnt != '0;
    assign bus.gnt    = (cnt < CNT_W'(DEPTH)) || pop;
    assign push       = bus.req && bus.gnt;
    assign bus.rvalid = pop;
    assign bus.err    = pop;
    assign bus.rdata  = DATA_W'(ERR_DATA);
    assign bus.rid    = fifo[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr] <= bus.aid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/tile_obi_addr_demux.sv
// tile_obi_addr_demux: routes one OBI manager to N_SBR subordinates by address rule.
// Ports: clk_i, rst_ni (async active-low), addr_map_i (rules {idx,start,end}),
// mgr_* (manager address and response phase), sbr_* (per-subordinate arrays).
// Unmapped addresses go to an internal error responder. Outstanding requests may
// only target one destination at a time, which keeps responses in issue order.
module tile_obi_addr_demux
    import tile_obi_addr_demux_pkg::*;
#(
    parameter int unsigned N_SBR       = 2,
    parameter int unsigned N_ADDR_RULE = 2,
    parameter int unsigned N_MAX_TRAN  = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [N_ADDR_RULE-1:0][32+2*ADDR_W-1:0]  addr_map_i,
    input  logic                                     mgr_req_i,
    output logic                                     mgr_gnt_o,
    input  logic [ADDR_W-1:0]                        mgr_addr_i,
    input  logic                                     mgr_we_i,
    input  logic [DATA_W/8-1:0]                      mgr_be_i,
    input  logic [DATA_W-1:0]                        mgr_wdata_i,
    input  logic [ID_W-1:0]                          mgr_aid_i,
    output logic                                     mgr_rvalid_o,
    output logic [DATA_W-1:0]                        mgr_rdata_o,
    output logic                                     mgr_err_o,
    output logic [ID_W-1:0]                          mgr_rid_o,
    output logic [N_SBR-1:0]                         sbr_req_o,
    input  logic [N_SBR-1:0]                         sbr_gnt_i,
    output logic [N_SBR-1:0][ADDR_W-1:0]             sbr_addr_o,
    output logic [N_SBR-1:0]                         sbr_we_o,
    output logic [N_SBR-1:0][DATA_W/8-1:0]           sbr_be_o,
    output logic [N_SBR-1:0][DATA_W-1:0]             sbr_wdata_o,
    output logic [N_SBR-1:0][ID_W-1:0]               sbr_aid_o,
    input  logic [N_SBR-1:0]                         sbr_rvalid_i,
    input  logic [N_SBR-1:0][DATA_W-1:0]             sbr_rdata_i,
    input  logic [N_SBR-1:0]                         sbr_err_i,
    input  logic [N_SBR-1:0][ID_W-1:0]               sbr_rid_i
);
    localparam int unsigned SEL_W = N_SBR > 1 ? $clog2(N_SBR) : 1;
    localparam int unsigned CNT_W = $clog2(N_MAX_TRAN + 1);

    logic             found, dec_err, same_tgt, issue_ok, req_ok, hs, tgt_rvalid;
    logic [31:0]      rule_idx;
    logic [SEL_W-1:0] dec_sel, infl_sel;
    tgt_kind_e        dec_kind, infl_kind;
    logic [CNT_W-1:0] out_cnt;

    tile_obi_addr_demux_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) err_bus ();

    // Scanning upward and latching the first hit gives lowest-rule priority.
    always_comb begin
        found    = 1'b0;
        rule_idx = '0;
        for (int r = 0; r < N_ADDR_RULE; r++) begin
            if (!found && mgr_addr_i >= addr_map_i[r][2*ADDR_W-1:ADDR_W]
                       && mgr_addr_i <  addr_map_i[r][ADDR_W-1:0]) begin
                found    = 1'b1;
                rule_idx = addr_map_i[r][32+2*ADDR_W-1:2*ADDR_W];
            end
        end
    end

    assign dec_err  = !found || rule_idx >= 32'(N_SBR);
    assign dec_sel  = rule_idx[SEL_W-1:0];
    assign dec_kind = dec_err ? TGT_ERR : TGT_SBR;
    assign same_tgt = dec_kind == infl_kind && (dec_err || dec_sel == infl_sel);
    assign issue_ok = rst_ni && out_cnt < CNT_W'(N_MAX_TRAN) && (out_cnt == '0 || same_tgt);
    assign req_ok   = mgr_req_i && issue_ok;

    always_comb begin
        sbr_req_o   = '0;
        sbr_addr_o  = '0;
        sbr_we_o    = '0;
        sbr_be_o    = '0;
        sbr_wdata_o = '0;
        sbr_aid_o   = '0;
        for (int i = 0; i < N_SBR; i++) begin
            if (req_ok && !dec_err && dec_sel == SEL_W'(i)) begin
                sbr_req_o[i]   = 1'b1;
                sbr_addr_o[i]  = mgr_addr_i;
                sbr_we_o[i]    = mgr_we_i;
                sbr_be_o[i]    = mgr_be_i;
                sbr_wdata_o[i] = mgr_wdata_i;
                sbr_aid_o[i]   = mgr_aid_i;
            end
        end
    end

    assign err_bus.req   = req_ok && dec_err;
    assign err_bus.addr  = mgr_addr_i;
    assign err_bus.we    = mgr_we_i;
    assign err_bus.be    = mgr_be_i;
    assign err_bus.wdata = mgr_wdata_i;
    assign err_bus.aid   = mgr_aid_i;

    tile_obi_err_sbr #(.DEPTH(N_MAX_TRAN), .DATA_W(DATA_W), .ID_W(ID_W)) u_err (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (err_bus)
    );

    assign mgr_gnt_o = req_ok && (dec_err ? err_bus.gnt : sbr_gnt_i[dec_sel]);
    assign hs        = mgr_req_i && mgr_gnt_o;

    // Responses are accepted only from the in-flight target and only while
    // something is outstanding, so stray or post-reset responses are dropped.
    assign tgt_rvalid   = infl_kind == TGT_ERR ? err_bus.rvalid : sbr_rvalid_i[infl_sel];
    assign mgr_rvalid_o = rst_ni && out_cnt != '0 && tgt_rvalid;
    assign mgr_err_o    = mgr_rvalid_o && (infl_kind == TGT_ERR ? err_bus.err : sbr_err_i[infl_sel]);
    assign mgr_rdata_o  = !rst_ni ? '0 : infl_kind == TGT_ERR ? err_bus.rdata : sbr_rdata_i[infl_sel];
    assign mgr_rid_o    = !rst_ni ? '0 : infl_kind == TGT_ERR ? err_bus.rid : sbr_rid_i[infl_sel];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt   <= '0;
            infl_kind <= TGT_SBR;
            infl_sel  <= '0;
        end else begin
            if (hs) begin
                infl_kind <= dec_kind;
                infl_sel  <= dec_sel;
            end
            if (hs && !mgr_rvalid_o)      out_cnt <= out_cnt + 1'b1;
            else if (!hs && mgr_rvalid_o) out_cnt <= out_cnt - 1'b1;
        end
    end

endmodule
